// File: rtl/voxel_traverse_engine.sv
// voxel_traverse_engine
// Iterative single-ray DDA traversal engine. One ray is accepted over a
// valid/ready handshake. The engine then loops fetch -> wait -> evaluate ->
// step until it finds an occupied voxel (hit), leaves the grid (miss) or uses
// up MAX_STEPS (timeout). It returns one result over valid/ready.
// Occupancy is read through an external synchronous-read voxel RAM port.
//
// Ports
//   clk, rst_n                    clock, asynchronous active-low reset
//   i_ray_valid / o_ray_ready     ray request handshake
//   i_ray_id                      ray tag, returned with the result
//   i_ix/i_iy/i_iz                start voxel
//   i_sx/i_sy/i_sz                step sign per axis (1 = +1, 0 = -1)
//   i_next_x/y/z, i_inc_x/y/z     initial boundary timers and increments
//   o_res_valid / i_res_ready     result handshake, result held until accepted
//   o_res_id, o_res_hit, o_res_timeout, o_res_x/y/z, o_res_face, o_res_steps
//   o_ram_raddr / i_ram_rdata     voxel RAM read port, address {z,y,x}
//   o_busy                        engine not idle
module voxel_traverse_engine #(
  parameter int W         = 32,
  parameter int XYZ_BITS  = 5,
  parameter int GRID_MAX  = 31,
  parameter int MAX_STEPS = 96,
  parameter int STEP_W    = 8,
  parameter int RAM_LAT   = 2,
  parameter int ID_W      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_ray_valid,
  output logic                  o_ray_ready,
  input  logic [ID_W-1:0]       i_ray_id,
  input  logic [XYZ_BITS-1:0]   i_ix,
  input  logic [XYZ_BITS-1:0]   i_iy,
  input  logic [XYZ_BITS-1:0]   i_iz,
  input  logic                  i_sx,
  input  logic                  i_sy,
  input  logic                  i_sz,
  input  logic [W-1:0]          i_next_x,
  input  logic [W-1:0]          i_next_y,
  input  logic [W-1:0]          i_next_z,
  input  logic [W-1:0]          i_inc_x,
  input  logic [W-1:0]          i_inc_y,
  input  logic [W-1:0]          i_inc_z,
  output logic                  o_res_valid,
  input  logic                  i_res_ready,
  output logic [ID_W-1:0]       o_res_id,
  output logic                  o_res_hit,
  output logic                  o_res_timeout,
  output logic [XYZ_BITS-1:0]   o_res_x,
  output logic [XYZ_BITS-1:0]   o_res_y,
  output logic [XYZ_BITS-1:0]   o_res_z,
  output logic [2:0]            o_res_face,
  output logic [STEP_W-1:0]     o_res_steps,
  output logic [3*XYZ_BITS-1:0] o_ram_raddr,
  input  logic                  i_ram_rdata,
  output logic                  o_busy
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_EVAL  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam int CRD_W  = XYZ_BITS + 1;
  localparam int WAIT_W = $clog2(RAM_LAT + 1);

  // One extra bit so that both -1 and GRID_MAX+1 show up as "> GRID_MAX".
  function automatic logic [CRD_W-1:0] step_coord(input logic [XYZ_BITS-1:0] c,
                                                  input logic en, input logic s);
    if (!en)     return {1'b0, c};
    else if (s)  return {1'b0, c} + CRD_W'(1);
    else         return {1'b0, c} - CRD_W'(1);
  endfunction

  function automatic logic [W-1:0] sat_add(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum[W]) return {W{1'b1}};
    else        return sum[W-1:0];
  endfunction

  logic [2:0]            r_state;
  logic                  r_ray_ready;
  logic [ID_W-1:0]       r_id;
  logic [XYZ_BITS-1:0]   r_x, r_y, r_z;
  logic                  r_sx, r_sy, r_sz;
  logic [W-1:0]          r_tx, r_ty, r_tz;
  logic [W-1:0]          r_incx, r_incy, r_incz;
  logic [STEP_W-1:0]     r_steps;
  logic [2:0]            r_face;
  logic [WAIT_W-1:0]     r_wait;
  logic [3*XYZ_BITS-1:0] r_raddr;
  logic                  r_res_valid, r_res_hit, r_res_timeout;
  logic [ID_W-1:0]       r_res_id;
  logic [XYZ_BITS-1:0]   r_res_x, r_res_y, r_res_z;
  logic [2:0]            r_res_face;
  logic [STEP_W-1:0]     r_res_steps;

  logic [W-1:0]          w_min_xy, w_min;
  logic                  w_mx, w_my, w_mz;
  logic [2:0]            w_face;
  logic [CRD_W-1:0]      w_nx, w_ny, w_nz;
  logic                  w_oob, w_start_oob;

  // Step decision: minimum timer, tie mask, primary-axis face and next voxel.
  always_comb begin
    w_min_xy    = (r_tx < r_ty) ? r_tx : r_ty;
    w_min       = (w_min_xy < r_tz) ? w_min_xy : r_tz;
    w_mx        = (r_tx == w_min);
    w_my        = (r_ty == w_min);
    w_mz        = (r_tz == w_min);
    if (w_mx)      w_face = {2'd0, r_sx};
    else if (w_my) w_face = {2'd1, r_sy};
    else           w_face = {2'd2, r_sz};
    w_nx        = step_coord(r_x, w_mx, r_sx);
    w_ny        = step_coord(r_y, w_my, r_sy);
    w_nz        = step_coord(r_z, w_mz, r_sz);
    w_oob       = (w_nx > CRD_W'(GRID_MAX)) || (w_ny > CRD_W'(GRID_MAX)) ||
                  (w_nz > CRD_W'(GRID_MAX));
    w_start_oob = ({1'b0, i_ix} > CRD_W'(GRID_MAX)) || ({1'b0, i_iy} > CRD_W'(GRID_MAX)) ||
                  ({1'b0, i_iz} > CRD_W'(GRID_MAX));
  end

  // Traversal FSM, ray context and registered result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_ray_ready   <= 1'b0;
      r_id          <= {ID_W{1'b0}};
      r_x           <= {XYZ_BITS{1'b0}};
      r_y           <= {XYZ_BITS{1'b0}};
      r_z           <= {XYZ_BITS{1'b0}};
      r_sx          <= 1'b0;
      r_sy          <= 1'b0;
      r_sz          <= 1'b0;
      r_tx          <= {W{1'b0}};
      r_ty          <= {W{1'b0}};
      r_tz          <= {W{1'b0}};
      r_incx        <= {W{1'b0}};
      r_incy        <= {W{1'b0}};
      r_incz        <= {W{1'b0}};
      r_steps       <= {STEP_W{1'b0}};
      r_face        <= 3'b000;
      r_wait        <= {WAIT_W{1'b0}};
      r_raddr       <= {(3*XYZ_BITS){1'b0}};
      r_res_valid   <= 1'b0;
      r_res_hit     <= 1'b0;
      r_res_timeout <= 1'b0;
      r_res_id      <= {ID_W{1'b0}};
      r_res_x       <= {XYZ_BITS{1'b0}};
      r_res_y       <= {XYZ_BITS{1'b0}};
      r_res_z       <= {XYZ_BITS{1'b0}};
      r_res_face    <= 3'b000;
      r_res_steps   <= {STEP_W{1'b0}};
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_ray_ready && i_ray_valid) begin
            r_ray_ready <= 1'b0;
            r_id    <= i_ray_id;
            r_x     <= i_ix;   r_y    <= i_iy;   r_z    <= i_iz;
            r_sx    <= i_sx;   r_sy   <= i_sy;   r_sz   <= i_sz;
            r_tx    <= i_next_x; r_ty <= i_next_y; r_tz <= i_next_z;
            r_incx  <= i_inc_x;  r_incy <= i_inc_y; r_incz <= i_inc_z;
            r_steps <= {STEP_W{1'b0}};
            r_face  <= 3'b111;
            if (w_start_oob) begin
              // Start outside the grid: immediate miss, RAM untouched.
              r_state       <= S_DONE;
              r_res_valid   <= 1'b1;
              r_res_hit     <= 1'b0;
              r_res_timeout <= 1'b0;
              r_res_id      <= i_ray_id;
              r_res_x       <= i_ix;
              r_res_y       <= i_iy;
              r_res_z       <= i_iz;
              r_res_face    <= 3'b111;
              r_res_steps   <= {STEP_W{1'b0}};
            end else begin
              r_raddr <= {i_iz, i_iy, i_ix};
              r_state <= S_FETCH;
            end
          end else begin
            r_ray_ready <= 1'b1;
          end
        end
        S_FETCH: begin
          r_wait <= {WAIT_W{1'b0}};
          r_state <= (RAM_LAT > 1) ? S_WAIT : S_EVAL;
        end
        S_WAIT: begin
          // Stay RAM_LAT-1 cycles so EVAL lines up with the RAM data.
          if (r_wait == WAIT_W'(RAM_LAT - 2)) r_state <= S_EVAL;
          else                                r_wait  <= r_wait + WAIT_W'(1);
        end
        S_EVAL: begin
          if (i_ram_rdata || (r_steps == STEP_W'(MAX_STEPS))) begin
            r_state       <= S_DONE;
            r_res_valid   <= 1'b1;
            r_res_hit     <= i_ram_rdata;
            r_res_timeout <= ~i_ram_rdata;
            r_res_id      <= r_id;
            r_res_x       <= r_x;
            r_res_y       <= r_y;
            r_res_z       <= r_z;
            r_res_face    <= r_face;
            r_res_steps   <= r_steps;
          end else begin
            r_steps <= r_steps + STEP_W'(1);
            r_face  <= w_face;
            if (w_oob) begin
              // Exit: report the last in-bounds voxel with the exit face.
              r_state       <= S_DONE;
              r_res_valid   <= 1'b1;
              r_res_hit     <= 1'b0;
              r_res_timeout <= 1'b0;
              r_res_id      <= r_id;
              r_res_x       <= r_x;
              r_res_y       <= r_y;
              r_res_z       <= r_z;
              r_res_face    <= w_face;
              r_res_steps   <= r_steps + STEP_W'(1);
            end else begin
              r_x     <= w_nx[XYZ_BITS-1:0];
              r_y     <= w_ny[XYZ_BITS-1:0];
              r_z     <= w_nz[XYZ_BITS-1:0];
              if (w_mx) r_tx <= sat_add(r_tx, r_incx);
              if (w_my) r_ty <= sat_add(r_ty, r_incy);
              if (w_mz) r_tz <= sat_add(r_tz, r_incz);
              r_raddr <= {w_nz[XYZ_BITS-1:0], w_ny[XYZ_BITS-1:0], w_nx[XYZ_BITS-1:0]};
              r_state <= S_FETCH;
            end
          end
        end
        S_DONE: begin
          if (i_res_ready) begin
            r_res_valid <= 1'b0;
            r_ray_ready <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_ray_ready   = r_ray_ready;
  assign o_busy        = (r_state != S_IDLE);
  assign o_ram_raddr   = r_raddr;
  assign o_res_valid   = r_res_valid;
  assign o_res_id      = r_res_id;
  assign o_res_hit     = r_res_hit;
  assign o_res_timeout = r_res_timeout;
  assign o_res_x       = r_res_x;
  assign o_res_y       = r_res_y;
  assign o_res_z       = r_res_z;
  assign o_res_face    = r_res_face;
  assign o_res_steps   = r_res_steps;

endmodule

// File: tb/tb_voxel_traverse_engine.sv
// Testbench for voxel_traverse_engine: directed scenarios plus random rays,
// every result compared against a behavioural DDA model and a RAM model.
module tb_voxel_traverse_engine;

  localparam int W         = 32;
  localparam int XYZ_BITS  = 5;
  localparam int GRID_MAX  = 29;
  localparam int MAX_STEPS = 8;
  localparam int STEP_W    = 8;
  localparam int RAM_LAT   = 2;
  localparam int ID_W      = 4;
  localparam longint TMAX  = 64'hFFFF_FFFF;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic i_ray_valid = 1'b0, i_res_ready = 1'b0;
  logic [ID_W-1:0] i_ray_id = '0;
  logic [XYZ_BITS-1:0] i_ix = '0, i_iy = '0, i_iz = '0;
  logic i_sx = 1'b0, i_sy = 1'b0, i_sz = 1'b0;
  logic [W-1:0] i_next_x = '0, i_next_y = '0, i_next_z = '0;
  logic [W-1:0] i_inc_x = '0, i_inc_y = '0, i_inc_z = '0;
  logic o_ray_ready, o_res_valid, o_res_hit, o_res_timeout, o_busy;
  logic [ID_W-1:0] o_res_id;
  logic [XYZ_BITS-1:0] o_res_x, o_res_y, o_res_z;
  logic [2:0] o_res_face;
  logic [STEP_W-1:0] o_res_steps;
  logic [3*XYZ_BITS-1:0] o_ram_raddr;
  logic i_ram_rdata;

  voxel_traverse_engine #(.W(W), .XYZ_BITS(XYZ_BITS), .GRID_MAX(GRID_MAX),
    .MAX_STEPS(MAX_STEPS), .STEP_W(STEP_W), .RAM_LAT(RAM_LAT), .ID_W(ID_W)) dut (
    .clk(clk), .rst_n(rst_n), .i_ray_valid(i_ray_valid), .o_ray_ready(o_ray_ready),
    .i_ray_id(i_ray_id), .i_ix(i_ix), .i_iy(i_iy), .i_iz(i_iz),
    .i_sx(i_sx), .i_sy(i_sy), .i_sz(i_sz),
    .i_next_x(i_next_x), .i_next_y(i_next_y), .i_next_z(i_next_z),
    .i_inc_x(i_inc_x), .i_inc_y(i_inc_y), .i_inc_z(i_inc_z),
    .o_res_valid(o_res_valid), .i_res_ready(i_res_ready), .o_res_id(o_res_id),
    .o_res_hit(o_res_hit), .o_res_timeout(o_res_timeout),
    .o_res_x(o_res_x), .o_res_y(o_res_y), .o_res_z(o_res_z),
    .o_res_face(o_res_face), .o_res_steps(o_res_steps),
    .o_ram_raddr(o_ram_raddr), .i_ram_rdata(i_ram_rdata), .o_busy(o_busy));

  always #5 clk = ~clk;

  // Voxel RAM model: data for the address seen in cycle c appears in cycle c+RAM_LAT.
  bit mem [0:32767];
  logic [1:0] ram_pipe = 2'b00;
  always @(posedge clk) ram_pipe <= {ram_pipe[0], mem[o_ram_raddr]};
  assign i_ram_rdata = ram_pipe[RAM_LAT-1];

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Current ray and model result.
  int     t_id;
  int     t_c [3];
  bit     t_s [3];
  longint t_t [3];
  longint t_inc [3];
  bit     m_hit, m_to;
  int     m_c [3];
  int     m_face, m_steps;

  function automatic int addr_of(int x, int y, int z);
    return z * 1024 + y * 32 + x;
  endfunction

  // Reference DDA walk on plain integers.
  task automatic model_ray();
    int c [3]; int nc [3]; longint t [3]; longint m; int prim; bit oob;
    for (int a = 0; a < 3; a++) begin c[a] = t_c[a]; t[a] = t_t[a]; end
    m_hit = 0; m_to = 0; m_face = 7; m_steps = 0;
    if (c[0] > GRID_MAX || c[1] > GRID_MAX || c[2] > GRID_MAX) begin
      for (int a = 0; a < 3; a++) m_c[a] = c[a];
      return;
    end
    for (int it = 0; it <= MAX_STEPS; it++) begin
      if (mem[addr_of(c[0], c[1], c[2])]) begin m_hit = 1; break; end
      if (m_steps == MAX_STEPS) begin m_to = 1; break; end
      m = t[0];
      if (t[1] < m) m = t[1];
      if (t[2] < m) m = t[2];
      prim = -1; oob = 0;
      for (int a = 0; a < 3; a++) begin
        nc[a] = c[a];
        if (t[a] == m) begin
          if (prim < 0) prim = a;
          nc[a] = c[a] + (t_s[a] ? 1 : -1);
          if (nc[a] < 0 || nc[a] > GRID_MAX) oob = 1;
          t[a] = t[a] + t_inc[a];
          if (t[a] > TMAX) t[a] = TMAX;
        end
      end
      m_steps++;
      m_face = prim * 2 + int'(t_s[prim]);
      if (oob) break;
      for (int a = 0; a < 3; a++) c[a] = nc[a];
    end
    for (int a = 0; a < 3; a++) m_c[a] = c[a];
  endtask

  task automatic check_res(input string tag);
    chk({tag, ":valid"}, o_res_valid, 1);
    chk({tag, ":id"}, o_res_id, t_id);
    chk({tag, ":hit"}, o_res_hit, m_hit);
    chk({tag, ":timeout"}, o_res_timeout, m_to);
    chk({tag, ":xyz"}, {o_res_z, o_res_y, o_res_x},
        {m_c[2][4:0], m_c[1][4:0], m_c[0][4:0]});
    chk({tag, ":face"}, o_res_face, m_face);
    chk({tag, ":steps"}, o_res_steps, m_steps);
  endtask

  task automatic drive_ray();
    i_ray_id = t_id[ID_W-1:0];
    i_ix = t_c[0][4:0]; i_iy = t_c[1][4:0]; i_iz = t_c[2][4:0];
    i_sx = t_s[0]; i_sy = t_s[1]; i_sz = t_s[2];
    i_next_x = t_t[0][31:0]; i_next_y = t_t[1][31:0]; i_next_z = t_t[2][31:0];
    i_inc_x = t_inc[0][31:0]; i_inc_y = t_inc[1][31:0]; i_inc_z = t_inc[2][31:0];
    i_ray_valid = 1'b1;
  endtask

  // Run one ray to completion; exp_lat > 0 checks the accept-to-result latency.
  task automatic run_ray(input string tag, input int hold, input int exp_lat);
    int k;
    logic [3*XYZ_BITS-1:0] addr0;
    model_ray();
    @(negedge clk);
    chk({tag, ":ready"}, o_ray_ready, 1);
    addr0 = o_ram_raddr;
    drive_ray();
    @(posedge clk);
    @(negedge clk);
    i_ray_valid = 1'b0;
    k = 0;
    while (!o_res_valid && k < 200) begin @(negedge clk); k++; end
    if (!o_res_valid) begin
      chk({tag, ":done_in_time"}, 0, 1);
    end else begin
      if (exp_lat > 0) chk({tag, ":latency"}, k + 1, exp_lat);
      if (exp_lat == 1) chk({tag, ":no_ram"}, o_ram_raddr, addr0);
      check_res(tag);
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        check_res({tag, ":hold"});
        chk({tag, ":hold_ready"}, o_ray_ready, 0);
      end
      i_res_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      i_res_ready = 1'b0;
      chk({tag, ":released"}, o_res_valid, 0);
      chk({tag, ":ready_after"}, o_ray_ready, 1);
    end
  endtask

  task automatic set_ray(input int id, input int x, input int y, input int z,
                         input bit sx, input bit sy, input bit sz,
                         input longint tx, input longint ty, input longint tz,
                         input longint ix, input longint iy, input longint iz);
    t_id = id; t_c[0] = x; t_c[1] = y; t_c[2] = z;
    t_s[0] = sx; t_s[1] = sy; t_s[2] = sz;
    t_t[0] = tx; t_t[1] = ty; t_t[2] = tz;
    t_inc[0] = ix; t_inc[1] = iy; t_inc[2] = iz;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 32768; i++) mem[i] = 0;
  endtask

  initial begin
    clear_mem();
    repeat (3) @(negedge clk);
    chk("rst:res_valid", o_res_valid, 0);
    chk("rst:busy", o_busy, 0);
    chk("rst:raddr", o_ram_raddr, 0);
    chk("rst:res", {o_res_hit, o_res_timeout, o_res_face, o_res_steps, o_res_x}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst:ready", o_ray_ready, 1);

    // Hit at the start voxel, latency RAM_LAT+2.
    mem[addr_of(3, 3, 3)] = 1;
    set_ray(1, 3, 3, 3, 1, 1, 1, 4, 5, 6, 1, 1, 1);
    run_ray("T1", 0, RAM_LAT + 2);
    chk("T1:model_hit", m_hit, 1);

    // Two X steps to an occupied voxel.
    clear_mem(); mem[addr_of(2, 0, 0)] = 1;
    set_ray(2, 0, 0, 0, 1, 1, 1, 1, 6, 9, 4, 4, 4);
    run_ray("T2", 0, 0);

    // Exit through the +X face at the grid edge.
    clear_mem();
    set_ray(3, GRID_MAX, 5, 5, 1, 1, 1, 1, 10, 20, 4, 4, 4);
    run_ray("T3", 0, 0);

    // Three-way tie steps diagonally.
    mem[addr_of(1, 1, 1)] = 1;
    set_ray(4, 0, 0, 0, 1, 1, 1, 7, 7, 7, 3, 3, 3);
    run_ray("T4", 0, 0);

    // Timeout with the result held for 5 cycles.
    clear_mem();
    set_ray(5, 10, 10, 10, 0, 1, 0, 3, 4, 5, 2, 3, 4);
    run_ray("T5", 5, 0);

    // Start outside the grid: immediate miss without RAM access.
    set_ray(6, GRID_MAX + 1, 2, 2, 1, 1, 1, 1, 2, 3, 1, 1, 1);
    run_ray("OOB", 1, 1);

    // Saturating timers force a late three-way tie.
    mem[addr_of(11, 11, 11)] = 1;
    set_ray(7, 10, 10, 10, 1, 1, 1, 64'hFFFF_FFF0, 64'hFFFF_FFF8, 64'hFFFF_FFFF,
            64'h8000_0000, 64'h8000_0000, 64'h8000_0000);
    run_ray("SAT", 0, 0);

    // Reset in the WAIT cycle of the fourth voxel aborts the ray.
    clear_mem();
    set_ray(8, 10, 10, 10, 1, 1, 1, 0, 0, 0, 1, 1, 1);
    @(negedge clk);
    drive_ray();
    @(posedge clk);
    @(negedge clk);
    i_ray_valid = 1'b0;
    repeat (10) @(negedge clk);
    chk("T6:busy_before", o_busy, 1);
    rst_n = 1'b0;
    #1;
    chk("T6:busy", o_busy, 0);
    chk("T6:res_valid", o_res_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("T6:ready", o_ray_ready, 1);
    chk("T6:idle", o_busy, 0);
    mem[addr_of(3, 3, 3)] = 1;
    set_ray(9, 3, 3, 3, 0, 0, 0, 1, 1, 1, 1, 1, 1);
    run_ray("T6post", 0, RAM_LAT + 2);

    // Random rays through a sparse random scene.
    for (int i = 0; i < 32768; i++) mem[i] = ($urandom_range(0, 29) == 0);
    for (int r = 0; r < 40; r++) begin
      t_id = r & 15;
      for (int a = 0; a < 3; a++) begin
        t_c[a] = ($urandom_range(0, 15) == 0) ? $urandom_range(GRID_MAX + 1, 31)
                                              : $urandom_range(0, GRID_MAX);
        t_s[a] = 1'($urandom_range(0, 1));
        t_t[a] = longint'($urandom_range(0, 40));
        t_inc[a] = longint'($urandom_range(1, 12));
        if (r % 7 == 3) t_t[a] = TMAX - longint'($urandom_range(0, 20));
      end
      run_ray("RND", $urandom_range(0, 2), 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // Global time limit.
  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
